// File: rtl/ifft_4p_unit_pkg.sv
// Shared constants for the 4-point streaming IFFT: data width, guard bits, phases.
package ifft_4p_unit_pkg;
    localparam int DW_DEF = 16;
    localparam int GW     = 2;

    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_e;
    localparam phase_e PH_FIRE = PH3;
endpackage

// File: rtl/ifft_4p_unit_if.sv
// Sample-in / sample-out bus of the 4-point IFFT; master drives samples, slave returns results.
interface ifft_4p_unit_if #(parameter int DW = 16);
    logic                 in_valid;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;
    logic                 out_valid;
    logic                 out_sof;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;

    modport master (output in_valid, data_in_r, data_in_i,
                    input  out_valid, out_sof, data_out_r, data_out_i);
    modport slave  (input  in_valid, data_in_r, data_in_i,
                    output out_valid, out_sof, data_out_r, data_out_i);
endinterface

// File: rtl/ifft_4p_unit_r4_ibf.sv
// Combinational radix-4 inverse butterfly (W^-1 = +j) with 1/4 floor scaling.
module r4_ibf
    import ifft_4p_unit_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic signed [DW-1:0] x_r [4],
    input  logic signed [DW-1:0] x_i [4],
    output logic signed [DW-1:0] y_r [4],
    output logic signed [DW-1:0] y_i [4]
);
    localparam int W = DW + GW;

    logic signed [W-1:0] a_r [4];
    logic signed [W-1:0] a_i [4];
    logic signed [W-1:0] s_r [4];
    logic signed [W-1:0] s_i [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a_r[k] = W'(x_r[k]);
            a_i[k] = W'(x_i[k]);
        end
        s_r[0] = a_r[0] + a_r[1] + a_r[2] + a_r[3];
        s_i[0] = a_i[0] + a_i[1] + a_i[2] + a_i[3];
        s_r[1] = a_r[0] - a_i[1] - a_r[2] + a_i[3];
        s_i[1] = a_i[0] + a_r[1] - a_i[2] - a_r[3];
        s_r[2] = a_r[0] - a_r[1] + a_r[2] - a_r[3];
        s_i[2] = a_i[0] - a_i[1] + a_i[2] - a_i[3];
        s_r[3] = a_r[0] + a_i[1] - a_r[2] - a_i[3];
        s_i[3] = a_i[0] - a_r[1] - a_i[2] + a_r[3];
        // Dropping the two LSBs of the guarded sum is an arithmetic >>>2 (floor).
        for (int k = 0; k < 4; k++) begin
            y_r[k] = s_r[k][W-1:GW];
            y_i[k] = s_i[k][W-1:GW];
        end
    end
endmodule

// File: rtl/ifft_4p_unit.sv
// Streaming 4-point IFFT: one sample per accepted cycle in, one per accepted cycle out.
module ifft_4p_unit
    import ifft_4p_unit_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input logic           clk,
    input logic           rst_n,
    ifft_4p_unit_if.slave bus
);
    phase_e               phase, phase_nxt;
    logic signed [DW-1:0] r_r [3];
    logic signed [DW-1:0] r_i [3];
    logic                 primed;

    logic signed [DW-1:0] bx_r [4];
    logic signed [DW-1:0] bx_i [4];
    logic signed [DW-1:0] by_r [4];
    logic signed [DW-1:0] by_i [4];

    logic signed [DW-1:0] cand_r, cand_i;
    logic                 cand_vld, cand_sof;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bx_r[k] = r_r[k];
            bx_i[k] = r_i[k];
        end
        bx_r[3] = bus.data_in_r;
        bx_i[3] = bus.data_in_i;
    end

    r4_ibf #(.DW(DW)) u_bf (
        .x_r(bx_r), .x_i(bx_i), .y_r(by_r), .y_i(by_i)
    );

    // Phases 0..2 shift out the previous frame's y1..y3 while loading the new frame.
    always_comb begin
        phase_nxt = phase;
        cand_r    = '0;
        cand_i    = '0;
        cand_vld  = 1'b0;
        cand_sof  = 1'b0;
        if (bus.in_valid) phase_nxt = phase_e'(phase + 2'd1);
        case (phase)
            PH0: begin cand_r = r_r[0]; cand_i = r_i[0]; cand_vld = primed; end
            PH1: begin cand_r = r_r[1]; cand_i = r_i[1]; cand_vld = primed; end
            PH2: begin cand_r = r_r[2]; cand_i = r_i[2]; cand_vld = primed; end
            PH_FIRE: begin
                cand_r = by_r[0]; cand_i = by_i[0]; cand_vld = 1'b1; cand_sof = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase          <= PH0;
            primed         <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_sof    <= 1'b0;
            bus.data_out_r <= '0;
            bus.data_out_i <= '0;
            for (int k = 0; k < 3; k++) begin
                r_r[k] <= '0;
                r_i[k] <= '0;
            end
        end else begin
            phase         <= phase_nxt;
            bus.out_valid <= bus.in_valid & cand_vld;
            bus.out_sof   <= bus.in_valid & cand_sof;
            if (bus.in_valid & cand_vld) begin
                bus.data_out_r <= cand_r;
                bus.data_out_i <= cand_i;
            end
            if (bus.in_valid) begin
                case (phase)
                    PH0: begin r_r[0] <= bus.data_in_r; r_i[0] <= bus.data_in_i; end
                    PH1: begin r_r[1] <= bus.data_in_r; r_i[1] <= bus.data_in_i; end
                    PH2: begin r_r[2] <= bus.data_in_r; r_i[2] <= bus.data_in_i; end
                    PH_FIRE: begin
                        for (int k = 0; k < 3; k++) begin
                            r_r[k] <= by_r[k+1];
                            r_i[k] <= by_i[k+1];
                        end
                        primed <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifft_4p_unit.sv
// Scoreboard bench: a plain-arithmetic 4-point IDFT model feeds an expected queue, a monitor pops on out_valid.
module tb_ifft_4p_unit;
    localparam int DW = 16;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        logic                 sof;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    ifft_4p_unit_if #(.DW(DW)) bus ();

    ifft_4p_unit #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    exp_t sb[$];
    int   fr_r[4], fr_i[4];
    int   fr_n   = 0;
    int   errors = 0;
    int   checks = 0;

    // Direct IDFT: y_k = floor( sum_n x_n * j^(n*k) / 4 ); frame outputs stream out in order.
    task automatic model_accept(input int xr, input int xi);
        exp_t e;
        int   sr, si, m;
        fr_r[fr_n] = xr;
        fr_i[fr_n] = xi;
        fr_n++;
        if (fr_n == 4) begin
            for (int k = 0; k < 4; k++) begin
                sr = 0; si = 0;
                for (int n = 0; n < 4; n++) begin
                    m = (n * k) % 4;
                    case (m)
                        0: begin sr += fr_r[n]; si += fr_i[n]; end
                        1: begin sr -= fr_i[n]; si += fr_r[n]; end
                        2: begin sr -= fr_r[n]; si -= fr_i[n]; end
                        default: begin sr += fr_i[n]; si -= fr_r[n]; end
                    endcase
                end
                e.r   = DW'(sr >>> 2);
                e.i   = DW'(si >>> 2);
                e.sof = (k == 0);
                sb.push_back(e);
            end
            fr_n = 0;
        end
    endtask

    task automatic send(input int xr, input int xi, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b1;
        bus.data_in_r = DW'(xr);
        bus.data_in_i = DW'(xi);
        model_accept(xr, xi);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int a_r, input int a_i, input int b_r, input int b_i,
                              input int c_r, input int c_i, input int d_r, input int d_i,
                              input int maxgap);
        send(a_r, a_i, maxgap);
        send(b_r, b_i, maxgap);
        send(c_r, c_i, maxgap);
        send(d_r, d_i, maxgap);
    endtask

    // Reset cycle with a live-looking sample that must be ignored; pending outputs are discarded.
    task automatic do_reset(input int cycles);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in_r = DW'($urandom);
        bus.data_in_i = DW'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        fr_n         = 0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    logic                 acc_q = 1'b0;
    logic                 rst_q = 1'b1;
    logic signed [DW-1:0] last_r = '0;
    logic signed [DW-1:0] last_i = '0;

    always @(posedge clk) begin
        acc_q <= rst_n && bus.in_valid;
        rst_q <= !rst_n;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_sof !== 1'b0 ||
                bus.data_out_r !== '0 || bus.data_out_i !== '0) begin
                errors++;
                $display("FAIL reset_state: got v=%b sof=%b (%0d,%0d) want v=0 sof=0 (0,0)",
                         bus.out_valid, bus.out_sof, bus.data_out_r, bus.data_out_i);
            end
            last_r = '0;
            last_i = '0;
        end else if (bus.out_valid === 1'b1) begin
            checks++;
            if (!acc_q) begin
                errors++;
                $display("FAIL valid_timing: out_valid=1 at %0t without an accepting cycle before it", $time);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got (%0d,%0d) sof=%b, want no output",
                         bus.data_out_r, bus.data_out_i, bus.out_sof);
            end else begin
                e = sb.pop_front();
                if (bus.data_out_r !== e.r || bus.data_out_i !== e.i || bus.out_sof !== e.sof) begin
                    errors++;
                    $display("FAIL sample: got (%0d,%0d) sof=%b, want (%0d,%0d) sof=%b at %0t",
                             bus.data_out_r, bus.data_out_i, bus.out_sof, e.r, e.i, e.sof, $time);
                end
            end
            last_r = bus.data_out_r;
            last_i = bus.data_out_i;
        end else begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_sof !== 1'b0 ||
                bus.data_out_r !== last_r || bus.data_out_i !== last_i) begin
                errors++;
                $display("FAIL idle_hold: got v=%b sof=%b (%0d,%0d), want v=0 sof=0 (%0d,%0d)",
                         bus.out_valid, bus.out_sof, bus.data_out_r, bus.data_out_i, last_r, last_i);
            end
        end
    end

    initial begin
        int xr, xi;
        bus.in_valid  = 1'b0;
        bus.data_in_r = '0;
        bus.data_in_i = '0;
        do_reset(2);
        repeat (2) @(posedge clk);
        #1;

        // Impulse, shifted impulse (back to back and with stalls), full scale, floor rounding.
        send_frame(4, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 4, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 4, 0, 0, 0, 0, 0, 3);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 3);
        send_frame(32767, 0, 32767, 0, 32767, 0, 32767, 0, 0);
        send_frame(-32768, 0, -32768, 0, -32768, 0, -32768, 0, 1);
        send_frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 2);

        // Reset mid-frame, then an impulse frame must start cleanly.
        send(7, 3, 0);
        send(-5, 9, 0);
        do_reset(1);
        send_frame(4, 0, 0, 0, 0, 0, 0, 0, 2);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random frames with random stalls, including full-scale extremes.
        for (int f = 0; f < 150; f++) begin
            for (int s = 0; s < 4; s++) begin
                xr = int'($urandom_range(0, 65535)) - 32768;
                xi = int'($urandom_range(0, 65535)) - 32768;
                if ($urandom_range(0, 9) == 0) xr = -32768;
                if ($urandom_range(0, 9) == 0) xi = 32767;
                send(xr, xi, (f % 3 == 0) ? 0 : 4);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        // The final frame's y1..y3 stay held until another frame arrives.
        checks++;
        if (sb.size() != 3) begin
            errors++;
            $display("FAIL drain_count: got %0d outstanding, want 3", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
